// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic MDU_OP_MUL = 1'b0;
  localparam logic MDU_OP_DIV = 1'b1;

  // Widest value the helper handles; covers 2*WIDTH results for WIDTH <= 64.
  localparam int MDU_MAX_W = 128;

  // Two's-complement magnitude / conditional negate; callers truncate to their width.
  function automatic logic [MDU_MAX_W-1:0] cond_neg(input logic [MDU_MAX_W-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = {1'b0, shifted} - {2'b00, div_i};
    q_o     = ~diff[WIDTH+1];
    rem_o   = q_o ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit, result {hi,lo}; MDU_EARLY_OUT_EN enables multiply early exit.
//   state | meaning
//   IDLE  | waiting for start_i
//   CALC  | one shift-add or restoring step per edge
//   FIX   | sign correction, load result_o
//   DONE  | result held until ack_i
import mdu_pkg::*;

module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               op_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               ack_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e state_q, state_d;

  logic               op_q, neg_res_q, neg_rem_q;
  logic [CW-1:0]      cnt_q;
  // mul: a_q = shifted multiplicand, b_q = shifted multiplier, acc_q = product
  // div: a_q[WIDTH-1:0] = dividend turning into quotient, b_q = divisor, acc_q = remainder
  logic [2*WIDTH-1:0] a_q, acc_q, result_q;
  logic [WIDTH-1:0]   b_q;

  logic               accept, div_zero, calc_last, q_bit;
  logic [WIDTH-1:0]   mag_a, mag_b, quot_fix, rem_fix;
  logic [WIDTH:0]     rem_next;
  logic [2*WIDTH-1:0] prod_fix;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (acc_q[WIDTH-1:0]),
    .bit_i (a_q[WIDTH-1]),
    .div_i (b_q),
    .rem_o (rem_next),
    .q_o   (q_bit)
  );

  always_comb begin
    accept   = start_i & ~annul_i;
    div_zero = (op_i == MDU_OP_DIV) && (b_i == '0);
    mag_a    = WIDTH'(cond_neg(MDU_MAX_W'(a_i), signed_i & a_i[WIDTH-1]));
    mag_b    = WIDTH'(cond_neg(MDU_MAX_W'(b_i), signed_i & b_i[WIDTH-1]));
    prod_fix = (2*WIDTH)'(cond_neg(MDU_MAX_W'(acc_q), neg_res_q));
    quot_fix = WIDTH'(cond_neg(MDU_MAX_W'(a_q[WIDTH-1:0]), neg_res_q));
    rem_fix  = WIDTH'(cond_neg(MDU_MAX_W'(acc_q[WIDTH-1:0]), neg_rem_q));
  end

  always_comb begin
    calc_last = (cnt_q == LAST);
`ifdef MDU_EARLY_OUT_EN
    if (op_q == MDU_OP_MUL) calc_last = (b_q[WIDTH-1:1] == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = div_zero ? DONE : CALC;
      CALC:    if (calc_last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (annul_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else if (!annul_i) begin
      case (state_q)
        IDLE: if (start_i) begin
          op_q      <= op_i;
          neg_res_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_rem_q <= signed_i & a_i[WIDTH-1];
          cnt_q     <= '0;
          acc_q     <= '0;
          a_q       <= {{WIDTH{1'b0}}, mag_a};
          b_q       <= mag_b;
          // Divide by zero: quotient all ones, remainder is the raw dividend.
          if (div_zero) result_q <= {a_i, {WIDTH{1'b1}}};
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == MDU_OP_MUL) begin
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            acc_q            <= {{(WIDTH-1){1'b0}}, rem_next};
            a_q[WIDTH-1:0]   <= {a_q[WIDTH-2:0], q_bit};
          end
        end
        FIX: begin
          if (op_q == MDU_OP_MUL) result_q <= prod_fix;
          else                    result_q <= {rem_fix, quot_fix};
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (state_q == CALC) || (state_q == FIX);
  assign ready_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule
